// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl
//
// Purpose:
//   Request sequencer that sits directly upstream of the 8-bit stack-pointer
//   block. The control unit hands it PUSH / POP / LOAD / NOP requests over a
//   valid/ready handshake. For each request this block:
//     - drives the stack pointer's rw command and r0 load value,
//     - drives the data-memory strobes for the stack access,
//     - guards the FF..B0 stack window (TOP..LIMIT+1) against overflow and
//       underflow,
//     - reports completion (done), rejection (err) and POP data (rsp_data).
//
// Ports:
//   clk        clock, all state changes on posedge
//   rst        asynchronous active-high reset
//   req_valid  request present
//   req_ready  block can accept a request (IDLE only)
//   req_op     00 NOP, 01 PUSH, 10 POP, 11 LOAD
//   req_data   PUSH data or LOAD pointer value
//   done       one-cycle completion pulse
//   err        qualifies done: 1 = request rejected
//   rsp_data   POP result, held until the next POP completes
//   ovf_flag   sticky overflow (PUSH rejected at LIMIT)
//   unf_flag   sticky underflow (POP rejected at TOP)
//   flag_clr   clears both sticky flags; a same-cycle set wins
//   sp_addr    current stack-pointer value
//   sp_rw      stack-pointer command: 00 hold, 01 dec, 10 inc, 11 load
//   sp_r0      load value used with sp_rw = 11
//   mem_addr   data-memory address
//   mem_wdata  data-memory write data
//   mem_we     data-memory write strobe
//   mem_re     data-memory read strobe
//   mem_rdata  read data, valid exactly one cycle after mem_re
//
// Notes:
//   The stack pointer is write-then-decrement on PUSH, so it always names the
//   next free slot. A POP therefore increments first and reads afterwards.
//   The stack-pointer block has no reset; the control unit is expected to
//   issue LOAD TOP after rst before any PUSH or POP.
// ---------------------------------------------------------------------------
module stack_ctrl #(
  parameter logic [7:0] TOP   = 8'hFF,
  parameter logic [7:0] LIMIT = 8'hAF,
  parameter int         DW    = 8
) (
  input  logic          clk,
  input  logic          rst,

  // Request / response channel to the control unit
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [DW-1:0] req_data,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] rsp_data,

  // Sticky status
  output logic          ovf_flag,
  output logic          unf_flag,
  input  logic          flag_clr,

  // Stack-pointer block
  input  logic [7:0]    sp_addr,
  output logic [1:0]    sp_rw,
  output logic [7:0]    sp_r0,

  // Data memory
  output logic [7:0]    mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);

  // -------------------------------------------------------------------------
  // Encodings
  // -------------------------------------------------------------------------
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  localparam logic [1:0] SP_HOLD = 2'b00;
  localparam logic [1:0] SP_DEC  = 2'b01;
  localparam logic [1:0] SP_INC  = 2'b10;
  localparam logic [1:0] SP_LOAD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PUSH     = 3'd1,
    S_POP_INC  = 3'd2,
    S_POP_RD   = 3'd3,
    S_POP_WAIT = 3'd4,
    S_LOAD     = 3'd5,
    S_DONE     = 3'd6,
    S_ERR      = 3'd7
  } state_t;

  // -------------------------------------------------------------------------
  // State and captured request
  // -------------------------------------------------------------------------
  state_t        r_state;
  logic [1:0]    r_op;
  logic [DW-1:0] r_data;
  logic [DW-1:0] r_rsp;
  logic          r_ovf;
  logic          r_unf;

  logic          w_accept;
  logic          w_at_limit;
  logic          w_at_top;
  logic          w_set_ovf;
  logic          w_set_unf;

  // A request is only taken in IDLE; anything offered while busy is ignored.
  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign w_at_limit = (sp_addr == LIMIT);
  assign w_at_top   = (sp_addr == TOP);

  // The rejected op is remembered in r_op, so ERR knows which flag to raise.
  assign w_set_ovf  = (r_state == S_ERR) && (r_op == OP_PUSH);
  assign w_set_unf  = (r_state == S_ERR) && (r_op == OP_POP);

  // -------------------------------------------------------------------------
  // Sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_NOP;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= req_op;
            r_data <= req_data;
            case (req_op)
              OP_PUSH: r_state <= w_at_limit ? S_ERR : S_PUSH;
              OP_POP:  r_state <= w_at_top   ? S_ERR : S_POP_INC;
              OP_LOAD: r_state <= S_LOAD;
              default: r_state <= S_DONE;
            endcase
          end
        end
        S_PUSH:     r_state <= S_DONE;
        S_POP_INC:  r_state <= S_POP_RD;
        S_POP_RD:   r_state <= S_POP_WAIT;
        S_POP_WAIT: r_state <= S_DONE;
        S_LOAD:     r_state <= S_DONE;
        S_DONE:     r_state <= S_IDLE;
        S_ERR:      r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // POP result register
  // -------------------------------------------------------------------------
  // Memory answers one cycle after the POP_RD strobe, i.e. during POP_WAIT.
  // A reset before this point leaves the register at zero, discarding any
  // partially completed POP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp <= '0;
    end else if (r_state == S_POP_WAIT) begin
      r_rsp <= mem_rdata;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky flags
  // -------------------------------------------------------------------------
  // Each flag is evaluated on its own: a set in ERR beats a coincident clear,
  // while the other flag still honours the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_set_ovf)     r_ovf <= 1'b1;
      else if (flag_clr) r_ovf <= 1'b0;

      if (w_set_unf)     r_unf <= 1'b1;
      else if (flag_clr) r_unf <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode
  // -------------------------------------------------------------------------
  // All command and strobe outputs decode straight from the state, so an
  // asynchronous reset drops them in the same instant the state returns to
  // IDLE. ERR deliberately leaves sp_rw at hold and issues no memory access.
  always_comb begin
    req_ready = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    sp_rw     = SP_HOLD;
    sp_r0     = 8'h00;
    mem_addr  = 8'h00;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;

    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
      end
      S_PUSH: begin
        // Write the free slot, then step the pointer down to the next one.
        mem_we    = 1'b1;
        mem_addr  = sp_addr;
        mem_wdata = r_data;
        sp_rw     = SP_DEC;
      end
      S_POP_INC: begin
        sp_rw     = SP_INC;
      end
      S_POP_RD: begin
        // sp_addr has already been incremented and names the top entry.
        mem_re    = 1'b1;
        mem_addr  = sp_addr;
      end
      S_LOAD: begin
        // No window check: LOAD is the recovery path for any pointer value.
        sp_rw     = SP_LOAD;
        sp_r0     = 8'(r_data);
      end
      S_DONE: begin
        done      = 1'b1;
      end
      S_ERR: begin
        done      = 1'b1;
        err       = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  assign rsp_data = r_rsp;
  assign ovf_flag = r_ovf;
  assign unf_flag = r_unf;

endmodule

// File: tb/tb_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stack_ctrl
//
// Self-checking bench for stack_ctrl. Models the surrounding stack-pointer
// block and data memory as the environment, and keeps a transaction-level
// reference (pointer value, stack contents, response, flags) that predicts
// each request's outcome, latency and side effects.
// ---------------------------------------------------------------------------
module tb_stack_ctrl;

  localparam logic [7:0] TOP   = 8'hFF;
  localparam logic [7:0] LIMIT = 8'hAF;
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_data;
  logic       done;
  logic       err;
  logic [7:0] rsp_data;
  logic       ovf_flag;
  logic       unf_flag;
  logic       flag_clr;
  logic [7:0] sp_addr;
  logic [1:0] sp_rw;
  logic [7:0] sp_r0;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  stack_ctrl #(.TOP(TOP), .LIMIT(LIMIT), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .done(done), .err(err), .rsp_data(rsp_data),
    .ovf_flag(ovf_flag), .unf_flag(unf_flag), .flag_clr(flag_clr),
    .sp_addr(sp_addr), .sp_rw(sp_rw), .sp_r0(sp_r0),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  // Environment: stack-pointer block (no reset) and data memory.
  // DUT outputs are latched mid-cycle and applied on the following posedge.
  logic [7:0] env_sp;
  logic [7:0] env_mem [256];
  logic [7:0] env_rdata;
  logic       l_we, l_re;
  logic [1:0] l_rw;
  logic [7:0] l_addr, l_wdata, l_r0;

  always @(negedge clk) begin
    l_we <= mem_we; l_re <= mem_re; l_rw <= sp_rw;
    l_addr <= mem_addr; l_wdata <= mem_wdata; l_r0 <= sp_r0;
  end

  always @(posedge clk) begin
    if (l_we) env_mem[l_addr] <= l_wdata;
    if (l_re) env_rdata <= env_mem[l_addr];
    case (l_rw)
      2'b01:   env_sp <= env_sp - 8'd1;
      2'b10:   env_sp <= env_sp + 8'd1;
      2'b11:   env_sp <= l_r0;
      default: env_sp <= env_sp;
    endcase
  end

  assign sp_addr   = env_sp;
  assign mem_rdata = env_rdata;

  // Reference state
  logic [7:0] m_sp;
  bit         m_known;
  logic [7:0] m_mem [256];
  logic [7:0] m_rsp;
  bit         m_ovf, m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and check everything it should and should not do.
  // clr_err drives flag_clr during the completion cycle; noise offers junk
  // requests while the block is busy.
  task automatic do_req(input logic [1:0] op, input logic [7:0] d,
                        input bit clr_err, input bit noise);
    int         e_lat, lat, n_we, n_re;
    bit         e_err, seen, e_set_o, e_set_u, busy_ready;
    logic [7:0] e_rw_seq, rw_seq, we_addr, we_data, re_addr, r0_seen;
    logic [7:0] sp0, e_rsp, err_obs, rsp_obs;

    sp0 = m_sp; e_err = 0; e_rw_seq = 8'h00; e_rsp = m_rsp;
    e_set_o = 0; e_set_u = 0;
    case (op)
      OP_NOP:  e_lat = 1;
      OP_LOAD: begin e_lat = 2; e_rw_seq = 8'h03; m_sp = d; m_known = 1; end
      OP_PUSH: begin
        if (sp0 == LIMIT) begin e_err = 1; e_lat = 1; e_set_o = 1; end
        else begin
          e_lat = 2; e_rw_seq = 8'h01;
          m_mem[sp0] = d; m_sp = sp0 - 8'd1;
        end
      end
      default: begin
        if (sp0 == TOP) begin e_err = 1; e_lat = 1; e_set_u = 1; end
        else begin
          e_lat = 4; e_rw_seq = 8'h02;
          m_sp = sp0 + 8'd1; m_rsp = m_mem[m_sp]; e_rsp = m_rsp;
        end
      end
    endcase
    // Set beats a coincident clear; without a clear the flags just accumulate.
    m_ovf = e_set_o || (m_ovf && !clr_err);
    m_unf = e_set_u || (m_unf && !clr_err);

    for (int i = 0; i < 6 && !req_ready; i++) tick();
    chk("ready_before_req", req_ready, 1);
    req_valid = 1; req_op = op; req_data = d;
    tick();
    req_valid = 0; req_op = OP_NOP; req_data = 8'h00;

    lat = 1; seen = 0; n_we = 0; n_re = 0; rw_seq = 8'h00; busy_ready = 0;
    we_addr = 0; we_data = 0; re_addr = 0; r0_seen = 0; err_obs = 0; rsp_obs = 0;
    while (!seen && lat <= 8) begin
      if (mem_we) begin n_we++; we_addr = mem_addr; we_data = mem_wdata; end
      if (mem_re) begin n_re++; re_addr = mem_addr; end
      if (sp_rw == 2'b11) r0_seen = sp_r0;
      if (lat <= 4) rw_seq[2*(lat-1) +: 2] = sp_rw;
      if (req_ready) busy_ready = 1;
      if (done) begin
        seen = 1; err_obs = {7'd0, err}; rsp_obs = rsp_data;
        req_valid = 0;
        if (clr_err) flag_clr = 1;
      end else begin
        if (noise) begin
          req_valid = 1; req_op = 2'($urandom); req_data = 8'($urandom);
        end
        tick();
        lat++;
      end
    end
    chk("done_seen", seen, 1);
    chk("latency", lat, e_lat);
    chk("err", err_obs, {7'd0, e_err});
    chk("rsp_data", rsp_obs, e_rsp);
    chk("ready_low_busy", busy_ready, 0);
    chk("sp_rw_seq", rw_seq, e_rw_seq);
    chk("we_count", n_we, (op == OP_PUSH && !e_err) ? 1 : 0);
    chk("re_count", n_re, (op == OP_POP && !e_err) ? 1 : 0);
    if (op == OP_PUSH && !e_err) begin
      chk("push_addr", we_addr, sp0);
      chk("push_wdata", we_data, d);
    end
    if (op == OP_POP && !e_err) chk("pop_addr", re_addr, m_sp);
    if (op == OP_LOAD) chk("load_r0", r0_seen, d);

    tick();
    flag_clr = 0;
    chk("ready_after", req_ready, 1);
    chk("done_after", done, 0);
    chk("ovf_flag", ovf_flag, m_ovf);
    chk("unf_flag", unf_flag, m_unf);
    if (m_known) chk("sp_value", env_sp, m_sp);
  endtask

  task automatic clr_pulse();
    flag_clr = 1;
    tick();
    flag_clr = 0;
    m_ovf = 0; m_unf = 0;
    chk("clr_ovf", ovf_flag, 0);
    chk("clr_unf", unf_flag, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_sp_rw"}, sp_rw, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_re"}, mem_re, 0);
    chk({tag, "_rsp"}, rsp_data, 0);
    chk({tag, "_ovf"}, ovf_flag, 0);
    chk({tag, "_unf"}, unf_flag, 0);
    chk({tag, "_r0"}, sp_r0, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    logic [1:0] op;
    logic [7:0] d;
    int         sel;

    rst = 1; req_valid = 0; req_op = 0; req_data = 0; flag_clr = 0;
    env_sp = 8'h3C; env_rdata = 8'h00;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 8'(i) ^ 8'hA5;
      m_mem[i]   = 8'(i) ^ 8'hA5;
    end
    m_sp = 8'h3C; m_known = 0; m_rsp = 0; m_ovf = 0; m_unf = 0;

    tick(); tick();
    check_idle_outputs("reset");
    rst = 0;
    tick();

    // Directed sequence
    do_req(OP_LOAD, TOP, 0, 0);
    do_req(OP_PUSH, 8'h5A, 0, 0);
    do_req(OP_POP, 8'h00, 0, 0);
    chk("pop_5a", rsp_data, 8'h5A);
    do_req(OP_POP, 8'h00, 0, 0);           // underflow
    chk("unf_set", unf_flag, 1);
    clr_pulse();
    do_req(OP_NOP, 8'h00, 0, 1);
    do_req(OP_LOAD, LIMIT, 0, 0);
    do_req(OP_PUSH, 8'h11, 0, 0);          // overflow
    chk("ovf_set", ovf_flag, 1);
    do_req(OP_PUSH, 8'h22, 1, 0);          // overflow with coincident clear
    chk("ovf_set_wins", ovf_flag, 1);
    clr_pulse();

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      op = OP_PUSH;
      else if (sel < 7) op = OP_POP;
      else if (sel < 8) op = OP_NOP;
      else              op = OP_LOAD;
      d = 8'($urandom);
      if (op == OP_LOAD) begin
        case ($urandom_range(0, 4))
          0: d = LIMIT;
          1: d = LIMIT + 8'd2;
          2: d = TOP;
          3: d = TOP - 8'd2;
          default: d = 8'($urandom_range(int'(LIMIT), int'(TOP)));
        endcase
      end
      do_req(op, d, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 15) == 0) clr_pulse();
    end

    // Reset in the middle of a POP
    do_req(OP_LOAD, TOP, 0, 0);
    do_req(OP_PUSH, 8'h77, 0, 0);
    do_req(OP_POP, 8'h00, 0, 0);           // leaves rsp_data = 77
    do_req(OP_POP, 8'h00, 0, 0);           // underflow, unf stays set
    do_req(OP_PUSH, 8'h99, 0, 0);
    chk("pre_rst_rsp", rsp_data, 8'h77);
    req_valid = 1; req_op = OP_POP; req_data = 0;
    tick();
    req_valid = 0; req_op = OP_NOP;
    chk("mid_popinc_rw", sp_rw, 2'b10);
    tick();
    chk("mid_poprd_re", mem_re, 1);
    chk("mid_poprd_addr", mem_addr, TOP);
    #1 rst = 1;
    #1;
    chk("rst_async_re", mem_re, 0);
    chk("rst_async_rw", sp_rw, 0);
    chk("rst_async_done", done, 0);
    tick();
    chk("rst_hold_done", done, 0);
    rst = 0;
    m_known = 0; m_rsp = 0; m_ovf = 0; m_unf = 0;
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_rsp", rsp_data, 0);
    chk("post_rst_unf", unf_flag, 0);
    tick();
    chk("post_rst_done", done, 0);
    do_req(OP_LOAD, TOP, 0, 0);
    do_req(OP_PUSH, 8'h3E, 0, 0);
    do_req(OP_POP, 8'h00, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
